// File: rtl/clk_div_prog_if.sv
// Divisor load/busy handshake between a configuration master and the divider.
interface clk_div_prog_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] div_n;
    logic         div_load;
    logic         div_busy;
    logic         div_err;

    modport master (
        output div_n,
        output div_load,
        input  div_busy,
        input  div_err
    );

    modport slave (
        input  div_n,
        input  div_load,
        output div_busy,
        output div_err
    );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with 50% duty for odd and even
// divisors. A new divisor is only applied at a period boundary (or while
// idle), so clk_out never produces a runt pulse.
module clk_div_prog #(
    parameter int unsigned W         = 8,
    parameter int unsigned DEFAULT_N = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    clk_div_prog_if.slave         div_if,
    output logic [W-1:0]          n_active,
    output logic                  clk_out,
    output logic                  period_tick
);

    localparam int unsigned HW = W + 1;

    logic [W-1:0]  r_cnt;
    logic [W-1:0]  r_n_active;
    logic [W-1:0]  r_pend_n;
    logic          r_odd;
    logic          r_pending;
    logic          r_q_p;
    logic          r_q_n;
    logic          r_err;
    logic          r_tick;

    logic          w_wrap;
    logic          w_apply;
    logic [W-1:0]  w_n_eff;
    logic          w_odd_eff;
    logic [HW-1:0] w_h_eff;
    logic [W-1:0]  w_cnt_nx;
    logic          w_load_ok;
    logic          w_load_bad;

    // Boundary detection, divisor selection and next-count arithmetic.
    always_comb begin
        w_wrap     = (r_cnt == (r_n_active - W'(1)));
        w_apply    = r_pending & (w_wrap | ~en);
        w_n_eff    = w_apply ? r_pend_n    : r_n_active;
        w_odd_eff  = w_apply ? r_pend_n[0] : r_odd;
        // Computed one bit wider so N = 2^W-1 cannot overflow the +1.
        w_h_eff    = (HW'(w_n_eff) + HW'(1)) >> 1;
        // The wrap uses the old divisor: an apply edge always starts a new period.
        w_cnt_nx   = w_wrap ? '0 : (r_cnt + W'(1));
        w_load_ok  = div_if.div_load & (div_if.div_n >= W'(2));
        w_load_bad = div_if.div_load & (div_if.div_n <  W'(2));
    end

    // Period counter, high-phase flop and period tick; parked at N-1 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= W'(DEFAULT_N - 1);
            r_q_p  <= 1'b0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_cnt_nx;
            r_q_p  <= (HW'(w_cnt_nx) < w_h_eff);
            r_tick <= (w_cnt_nx == '0);
        end else begin
            r_cnt  <= w_n_eff - W'(1);
            r_q_p  <= 1'b0;
            r_tick <= 1'b0;
        end
    end

    // Active divisor and its parity, updated only on an apply edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n_active <= W'(DEFAULT_N);
            r_odd      <= ((DEFAULT_N % 2) == 1);
        end else if (w_apply) begin
            r_n_active <= w_n_eff;
            r_odd      <= w_odd_eff;
        end
    end

    // Pending divisor: last valid request wins, cleared when applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_n  <= '0;
            r_pending <= 1'b0;
        end else if (w_load_ok) begin
            r_pend_n  <= div_if.div_n;
            r_pending <= 1'b1;
        end else if (w_apply) begin
            r_pending <= 1'b0;
        end
    end

    // One-cycle error pulse for divisors below 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_load_bad;
        end
    end

    // Half-cycle helper: delays the high phase by half a clk for odd divisors.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_n <= 1'b0;
        end else begin
            r_q_n <= r_q_p;
        end
    end

    // Odd divisors trim half a cycle off the start of the high phase.
    always_comb begin
        clk_out = r_odd ? (r_q_p & r_q_n) : r_q_p;
    end

    assign n_active        = r_n_active;
    assign period_tick     = r_tick;
    assign div_if.div_busy = r_pending;
    assign div_if.div_err  = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: a period-position model predicts clk_out for each
// half clk cycle plus the handshake outputs; directed scenarios add
// hand-computed counts of high half-cycles and ticks per window.
module tb_clk_div_prog;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [W-1:0] n_active;
    logic         clk_out;
    logic         period_tick;

    clk_div_prog_if #(.W(W)) dif ();

    clk_div_prog #(.W(W), .DEFAULT_N(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .div_if      (dif),
        .n_active    (n_active),
        .clk_out     (clk_out),
        .period_tick (period_tick)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_err  = 0;
    int hi_cnt = 0;
    int tk_cnt = 0;
    bit chk_on = 1'b0;

    // Model: divisor in use, clk cycles since period start, pending request.
    int m_n      = 3;
    int m_k      = 2;
    int m_pend_n = 0;
    bit m_pend   = 1'b0;
    bit m_tick   = 1'b0;
    bit m_err    = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // High during the whole high phase for even N; odd N loses the first half-cycle.
    function automatic bit exp_hi(input int n, input int k, input bit second_half);
        int h;
        h = (n + 1) / 2;
        if ((n % 2) == 0) return (k < h);
        if (second_half)  return (k < h);
        return (k >= 1) && (k < h);
    endfunction

    // Advance the model one clk period from the inputs seen at the edge.
    always @(posedge clk or negedge rst_n) begin : mdl_step
        int old_n;
        bit apply;
        if (!rst_n) begin
            m_n = 3; m_k = 2; m_pend = 1'b0; m_pend_n = 0; m_tick = 1'b0; m_err = 1'b0;
        end else begin
            old_n = m_n;
            apply = m_pend && ((m_k == old_n - 1) || !en);
            if (apply) m_n = m_pend_n;
            if (en) m_k = (m_k == old_n - 1) ? 0 : m_k + 1;
            else    m_k = m_n - 1;
            m_tick = en && (m_k == 0);
            m_err  = dif.div_load && (dif.div_n < 2);
            if (dif.div_load && (dif.div_n >= 2)) begin
                m_pend   = 1'b1;
                m_pend_n = int'(dif.div_n);
            end else if (apply) begin
                m_pend = 1'b0;
            end
        end
    end

    // First half of each clk cycle: all outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            chk("clk_out_first_half", 32'(clk_out), 32'(exp_hi(m_n, m_k, 1'b0)));
            chk("period_tick", 32'(period_tick), 32'(m_tick));
            chk("div_busy", 32'(dif.div_busy), 32'(m_pend));
            chk("div_err", 32'(dif.div_err), 32'(m_err));
            chk("n_active", 32'(n_active), 32'(m_n));
            if (clk_out === 1'b1) hi_cnt++;
            if (period_tick === 1'b1) tk_cnt++;
        end
    end

    // Second half of each clk cycle: clk_out only.
    always @(negedge clk) begin
        #1;
        if (chk_on) begin
            chk("clk_out_second_half", 32'(clk_out), 32'(exp_hi(m_n, m_k, 1'b1)));
            if (clk_out === 1'b1) hi_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_k(input int k);
        for (int i = 0; i < 60; i++) begin
            if (m_k == k) return;
            step();
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_k: position %0d not reached, got %0d", k, m_k);
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < 60; i++) begin
            if (m_n == n) return;
            step();
        end
        n_chk++;
        n_err++;
        $display("FAIL wait_n: divisor %0d not applied, got %0d", n, m_n);
    endtask

    task automatic load(input int n);
        dif.div_n    = W'(n);
        dif.div_load = 1'b1;
        step();
        dif.div_load = 1'b0;
    endtask

    task automatic clr_meas();
        hi_cnt = 0;
        tk_cnt = 0;
    endtask

    initial begin
        dif.div_n    = '0;
        dif.div_load = 1'b0;
        repeat (3) step();
        rst_n  = 1'b1;
        chk_on = 1'b1;
        chk("reset_n_active", 32'(n_active), 32'd3);
        chk("reset_busy", 32'(dif.div_busy), 32'd0);
        chk("reset_clk_out", 32'(clk_out), 32'd0);
        chk("reset_tick", 32'(period_tick), 32'd0);

        // N=3 from reset: 3 high half-cycles and one tick per 3 clks.
        en = 1'b1;
        clr_meas();
        repeat (9) step();
        chk("n3_high_halves", 32'(hi_cnt), 32'd9);
        chk("n3_ticks", 32'(tk_cnt), 32'd3);

        // Load 4 at cnt=1; applies on the cnt=2 edge.
        wait_k(1);
        load(4);
        chk("n4_busy_pending", 32'(dif.div_busy), 32'd1);
        chk("n4_before_apply", 32'(n_active), 32'd3);
        step();
        chk("n4_applied", 32'(n_active), 32'd4);
        chk("n4_busy_clear", 32'(dif.div_busy), 32'd0);
        wait_k(3);
        clr_meas();
        repeat (8) step();
        chk("n4_high_halves", 32'(hi_cnt), 32'd8);
        chk("n4_ticks", 32'(tk_cnt), 32'd2);

        // Back-to-back loads 6 then 7: only 7 lands.
        wait_k(0);
        load(6);
        load(7);
        chk("n7_busy", 32'(dif.div_busy), 32'd1);
        chk("n7_still_4", 32'(n_active), 32'd4);
        wait_n(7);
        chk("n7_applied", 32'(n_active), 32'd7);
        chk("n7_busy_clear", 32'(dif.div_busy), 32'd0);
        wait_k(6);
        clr_meas();
        repeat (14) step();
        chk("n7_high_halves", 32'(hi_cnt), 32'd14);
        chk("n7_ticks", 32'(tk_cnt), 32'd2);

        // Illegal divisors 1 and 0.
        dif.div_n    = W'(1);
        dif.div_load = 1'b1;
        step();
        chk("err_div1", 32'(dif.div_err), 32'd1);
        dif.div_n = W'(0);
        step();
        dif.div_load = 1'b0;
        chk("err_div0", 32'(dif.div_err), 32'd1);
        step();
        chk("err_clears", 32'(dif.div_err), 32'd0);
        chk("err_n_kept", 32'(n_active), 32'd7);
        chk("err_not_busy", 32'(dif.div_busy), 32'd0);

        // N=5, drop en during the high phase, load 2 while idle.
        load(5);
        wait_n(5);
        wait_k(1);
        en = 1'b0;
        step();
        chk("idle_clk_out_low", 32'(clk_out), 32'd0);
        load(2);
        step();
        chk("idle_n2_applied", 32'(n_active), 32'd2);
        chk("idle_busy_clear", 32'(dif.div_busy), 32'd0);
        chk("idle_clk_out_still_low", 32'(clk_out), 32'd0);
        step();
        en = 1'b1;
        clr_meas();
        repeat (4) step();
        chk("n2_high_halves", 32'(hi_cnt), 32'd4);
        chk("n2_ticks", 32'(tk_cnt), 32'd2);

        // Async reset in the middle of an N=7 high phase.
        load(7);
        wait_n(7);
        wait_k(1);
        chk("pre_reset_high", 32'(clk_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_clk_out", 32'(clk_out), 32'd0);
        chk("async_reset_n", 32'(n_active), 32'd3);
        chk("async_reset_busy", 32'(dif.div_busy), 32'd0);
        step();
        rst_n = 1'b1;
        clr_meas();
        repeat (6) step();
        chk("post_reset_high_halves", 32'(hi_cnt), 32'd6);
        chk("post_reset_ticks", 32'(tk_cnt), 32'd2);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
